// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for the pipelined add/subtract unit.
interface pipe_addsub_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, op_a, op_b, op_sub, out_ready,
      input  in_ready, out_valid, sum, carry, ovf, zero
   );

   modport slave (
      input  in_valid, op_a, op_b, op_sub, out_ready,
      output in_ready, out_valid, sum, carry, ovf, zero
   );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES equal slices,
// one register stage per slice, with a valid/ready handshake on both sides.
module pipe_addsub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input logic          clk,
   input logic          rst,
   pipe_addsub_if.slave bus
);
   localparam int unsigned SW   = WIDTH / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   logic             advance;
   logic [WIDTH-1:0] b_eff;

   // The whole pipe moves together whenever the output slot is free or being drained.
   assign advance      = !g_stage[LAST].q_vld || bus.out_ready;
   assign bus.in_ready = advance || rst;
   assign b_eff        = bus.op_sub ? ~bus.op_b : bus.op_b;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned RI = WIDTH - k * SW;
      localparam int unsigned LO = (k + 1) * SW;

      logic [RI-1:0] sa;
      logic [RI-1:0] sb;
      logic          sc;
      logic          sv;
      logic [SW:0]   part;
      logic [LO-1:0] ns;
      logic          q_vld;
      logic          q_cy;
      logic [LO-1:0] q_sum;

      // Stage inputs: fresh beat for slice 0, previous stage register otherwise.
      if (k == 0) begin : g_src
         assign sa = bus.op_a;
         assign sb = b_eff;
         assign sc = bus.op_sub;
         assign sv = bus.in_valid;
         assign ns = part[SW-1:0];
      end else begin : g_src
         assign sa = g_stage[k-1].g_rem.q_a;
         assign sb = g_stage[k-1].g_rem.q_b;
         assign sc = g_stage[k-1].q_cy;
         assign sv = g_stage[k-1].q_vld;
         assign ns = {part[SW-1:0], g_stage[k-1].q_sum};
      end

      assign part = {1'b0, sa[SW-1:0]} + {1'b0, sb[SW-1:0]} + (SW+1)'(sc);

      always_ff @(posedge clk) begin
         if (rst) begin
            q_vld <= 1'b0;
            q_cy  <= 1'b0;
            q_sum <= '0;
         end else if (advance) begin
            q_vld <= sv;
            q_cy  <= part[SW];
            q_sum <= ns;
         end
      end

      if (k < LAST) begin : g_rem
         // Only the operand bits still to be summed travel down the pipe.
         logic [RI-SW-1:0] q_a;
         logic [RI-SW-1:0] q_b;

         always_ff @(posedge clk) begin
            if (rst) begin
               q_a <= '0;
               q_b <= '0;
            end else if (advance) begin
               q_a <= sa[RI-1:SW];
               q_b <= sb[RI-1:SW];
            end
         end
      end else begin : g_flags
         // Top slice still holds the A and B' sign bits, so flags register with the sum.
         logic q_ovf;
         logic q_zero;

         always_ff @(posedge clk) begin
            if (rst) begin
               q_ovf  <= 1'b0;
               q_zero <= 1'b0;
            end else if (advance) begin
               q_ovf  <= (sa[RI-1] == sb[RI-1]) && (ns[LO-1] != sa[RI-1]);
               q_zero <= (ns == '0);
            end
         end
      end
   end

   assign bus.out_valid = g_stage[LAST].q_vld;
   assign bus.sum       = g_stage[LAST].q_sum;
   assign bus.carry     = g_stage[LAST].q_cy;
   assign bus.ovf       = g_stage[LAST].g_flags.q_ovf;
   assign bus.zero      = g_stage[LAST].g_flags.q_zero;
endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: directed cases on a 32/2 unit plus a
// random sweep over several WIDTH/STAGES configurations.
module tb_pipe_addsub;
   localparam int unsigned NCFG       = 7;
   localparam int          RND_CYCLES = 18000;
   localparam int          DRAIN      = 60;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   logic [34:0] dq[$];
   logic [34:0] rq[NCFG][$];

   logic [NCFG-1:0] r_iv, r_sub, r_ordy, r_ir, r_ov, r_took;
   logic [31:0]     r_a[NCFG];
   logic [31:0]     r_b[NCFG];
   logic [34:0]     r_res[NCFG];

   function automatic int unsigned cfg_w(input int g);
      return (g < 4) ? 32 : 8;
   endfunction

   function automatic int unsigned cfg_s(input int g);
      case (g)
         0: return 1;
         1: return 2;
         2: return 4;
         3: return 32;
         4: return 1;
         5: return 4;
         default: return 8;
      endcase
   endfunction

   // Reference: {sum[31:0], carry, ovf, zero} for a w-bit add/sub.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic sub, input int unsigned w);
      logic [63:0] mask, aa, bb, t, s;
      mask = (64'd1 << w) - 64'd1;
      aa   = 64'(a) & mask;
      bb   = (sub ? ~64'(b) : 64'(b)) & mask;
      t    = aa + bb + 64'(sub);
      s    = t & mask;
      return {s[31:0], t[w], (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]), s == 64'd0};
   endfunction

   pipe_addsub_if #(.WIDTH(32)) dif ();
   pipe_addsub #(.WIDTH(32), .STAGES(2)) u_dut (.clk(clk), .rst(rst), .bus(dif));

   for (genvar g = 0; g < NCFG; g++) begin : g_cfg
      localparam int unsigned W = cfg_w(g);
      localparam int unsigned S = cfg_s(g);
      pipe_addsub_if #(.WIDTH(W)) rif ();
      pipe_addsub #(.WIDTH(W), .STAGES(S)) u_rnd (.clk(clk), .rst(rst), .bus(rif));
      assign rif.in_valid  = r_iv[g];
      assign rif.op_a      = r_a[g][W-1:0];
      assign rif.op_b      = r_b[g][W-1:0];
      assign rif.op_sub    = r_sub[g];
      assign rif.out_ready = r_ordy[g];
      assign r_ir[g]       = rif.in_ready;
      assign r_ov[g]       = rif.out_valid;
      assign r_res[g]      = {32'(rif.sum), rif.carry, rif.ovf, rif.zero};
   end

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      dif.in_valid = 1'b1; dif.op_a = 32'd5; dif.op_b = 32'd7; dif.op_sub = 1'b0;
      dif.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_chk++;
      if (dif.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", dif.in_ready);
      else n_pass++;
      n_chk++;
      if ({dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero} !== 36'd0)
         $display("FAIL reset_outputs: got %h expected 0",
                  {dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      dif.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_chk++;
      if (dif.out_valid !== 1'b0) $display("FAIL reset_no_capture: out_valid %b expected 0", dif.out_valid);
      else n_pass++;
   endtask

   task automatic test_carry_chain();
      logic [34:0] exp;
      @(negedge clk);
      dif.in_valid = 1'b1; dif.op_a = 32'h0000_FFFF; dif.op_b = 32'h1; dif.op_sub = 1'b0;
      dif.out_ready = 1'b1;
      #1;
      n_chk++;
      if (dif.in_ready !== 1'b1) $display("FAIL chain_in_ready: got %b expected 1", dif.in_ready);
      else n_pass++;
      dq.push_back({32'h0001_0000, 3'b000});
      @(negedge clk);
      dif.in_valid = 1'b0;
      #1;
      n_chk++;
      if (dif.out_valid !== 1'b0) $display("FAIL chain_latency_early: out_valid %b expected 0", dif.out_valid);
      else n_pass++;
      @(negedge clk);
      #1;
      n_chk++;
      if (dif.out_valid !== 1'b1) $display("FAIL chain_latency: out_valid %b expected 1", dif.out_valid);
      else n_pass++;
      exp = dq.pop_front();
      n_chk++;
      if ({dif.sum, dif.carry, dif.ovf, dif.zero} !== exp)
         $display("FAIL chain_result: got %h expected %h", {dif.sum, dif.carry, dif.ovf, dif.zero}, exp);
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_flags();
      logic [31:0] ta[5] = '{32'h7FFF_FFFF, 32'd5, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] tb[5] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd1};
      logic        ts[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [34:0] te[5] = '{{32'h8000_0000, 3'b010}, {32'h0000_0000, 3'b101},
                             {32'hFFFF_FFFF, 3'b000}, {32'h7FFF_FFFF, 3'b110},
                             {32'h0000_0000, 3'b101}};
      logic [34:0] exp;
      int sent = 0;
      int got  = 0;
      for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
         @(negedge clk);
         dif.out_ready = 1'b1;
         dif.in_valid  = (sent < 5);
         if (sent < 5) begin
            dif.op_a = ta[sent]; dif.op_b = tb[sent]; dif.op_sub = ts[sent];
         end
         #1;
         if (dif.out_valid && dif.out_ready) begin
            exp = (dq.size() != 0) ? dq.pop_front() : 35'h0;
            n_chk++;
            if ({dif.sum, dif.carry, dif.ovf, dif.zero} !== exp)
               $display("FAIL flags_beat%0d: got %h expected %h", got,
                        {dif.sum, dif.carry, dif.ovf, dif.zero}, exp);
            else n_pass++;
            got++;
         end
         if (dif.in_valid && dif.in_ready) begin
            dq.push_back(te[sent]);
            sent++;
         end
      end
      n_chk++;
      if (got != 5) $display("FAIL flags_count: got %0d results expected 5", got);
      else n_pass++;
      @(negedge clk);
      dif.in_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] ba[8], bb[8];
      logic        bs[8];
      logic [34:0] exp;
      int sent = 0;
      int got  = 0;
      for (int i = 0; i < 8; i++) begin
         ba[i] = 32'h9E37_79B9 * 32'(i + 1);
         bb[i] = 32'h7F4A_7C15 ^ (32'(i) << 28);
         bs[i] = (i % 2) == 1;
      end
      for (int c = 0; c < 40 && got < 8; c++) begin
         @(negedge clk);
         dif.out_ready = !(c >= 3 && c <= 5);
         dif.in_valid  = (sent < 8);
         if (sent < 8) begin
            dif.op_a = ba[sent]; dif.op_b = bb[sent]; dif.op_sub = bs[sent];
         end
         #1;
         if (c >= 3 && c <= 5) begin
            n_chk++;
            if (dif.in_ready !== 1'b0) $display("FAIL stall_in_ready_c%0d: got %b expected 0", c, dif.in_ready);
            else n_pass++;
            exp = (dq.size() != 0) ? dq[0] : 35'h0;
            n_chk++;
            if ({dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero} !== {1'b1, exp})
               $display("FAIL stall_hold_c%0d: got %h expected %h", c,
                        {dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero}, {1'b1, exp});
            else n_pass++;
         end
         if (dif.out_valid && dif.out_ready) begin
            exp = (dq.size() != 0) ? dq.pop_front() : 35'h0;
            n_chk++;
            if ({dif.sum, dif.carry, dif.ovf, dif.zero} !== exp)
               $display("FAIL stream_beat%0d: got %h expected %h", got,
                        {dif.sum, dif.carry, dif.ovf, dif.zero}, exp);
            else n_pass++;
            got++;
         end
         if (dif.in_valid && dif.in_ready) begin
            dq.push_back(model(ba[sent], bb[sent], bs[sent], 32));
            sent++;
         end
      end
      n_chk++;
      if (got != 8 || dq.size() != 0)
         $display("FAIL stream_count: got %0d results (%0d pending) expected 8", got, dq.size());
      else n_pass++;
      @(negedge clk);
      dif.in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [34:0] exp;
      @(negedge clk);
      dif.out_ready = 1'b0;
      dif.in_valid = 1'b1; dif.op_a = 32'd10; dif.op_b = 32'd20; dif.op_sub = 1'b0;
      @(negedge clk);
      dif.op_a = 32'd30; dif.op_b = 32'd40;
      @(negedge clk);
      rst = 1'b1;
      dif.op_a = 32'd50; dif.op_b = 32'd60;
      #1;
      n_chk++;
      if (dif.in_ready !== 1'b1) $display("FAIL midrst_in_ready_during: got %b expected 1", dif.in_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      dif.in_valid = 1'b0;
      dif.out_ready = 1'b1;
      #1;
      n_chk++;
      if ({dif.in_ready, dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero} !== {1'b1, 36'd0})
         $display("FAIL midrst_outputs: got %h expected %h",
                  {dif.in_ready, dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero}, {1'b1, 36'd0});
      else n_pass++;
      dq.delete();
      @(negedge clk);
      dif.in_valid = 1'b1; dif.op_a = 32'hFFFF_FFFF; dif.op_b = 32'hFFFF_FFFF; dif.op_sub = 1'b0;
      #1;
      if (dif.in_ready) dq.push_back({32'hFFFF_FFFE, 3'b100});
      @(negedge clk);
      dif.in_valid = 1'b0;
      #1;
      n_chk++;
      if (dif.out_valid !== 1'b0) $display("FAIL midrst_latency_early: out_valid %b expected 0", dif.out_valid);
      else n_pass++;
      @(negedge clk);
      #1;
      exp = (dq.size() != 0) ? dq.pop_front() : 35'h0;
      n_chk++;
      if ({dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero} !== {1'b1, exp})
         $display("FAIL midrst_first_beat: got %h expected %h",
                  {dif.out_valid, dif.sum, dif.carry, dif.ovf, dif.zero}, {1'b1, exp});
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [34:0] exp;
      for (int cyc = 0; cyc < RND_CYCLES + DRAIN; cyc++) begin
         @(negedge clk);
         for (int g = 0; g < NCFG; g++) begin
            if (r_took[g] || !r_iv[g]) begin
               if (cyc < RND_CYCLES) begin
                  r_iv[g]  = ($urandom_range(3) != 0);
                  r_a[g]   = $urandom;
                  r_b[g]   = ($urandom_range(7) == 0) ? r_a[g] : $urandom;
                  r_sub[g] = 1'($urandom_range(1));
               end else begin
                  r_iv[g] = 1'b0;
               end
            end
            r_ordy[g] = (cyc >= RND_CYCLES) || ($urandom_range(3) != 0);
         end
         #1;
         for (int g = 0; g < NCFG; g++) begin
            r_took[g] = r_iv[g] && r_ir[g];
            if (r_ov[g] && r_ordy[g]) begin
               exp = (rq[g].size() != 0) ? rq[g].pop_front() : 35'h7_FFFF_FFFF;
               n_chk++;
               if (r_res[g] !== exp)
                  $display("FAIL random_w%0d_s%0d: got %h expected %h", cfg_w(g), cfg_s(g), r_res[g], exp);
               else n_pass++;
            end
            if (r_took[g]) rq[g].push_back(model(r_a[g], r_b[g], r_sub[g], cfg_w(g)));
         end
      end
      for (int g = 0; g < NCFG; g++) begin
         n_chk++;
         if (rq[g].size() != 0)
            $display("FAIL random_drain_w%0d_s%0d: %0d results pending expected 0", cfg_w(g), cfg_s(g), rq[g].size());
         else n_pass++;
      end
   endtask

   initial begin
      clk    = 1'b0;
      rst    = 1'b1;
      n_chk  = 0;
      n_pass = 0;
      r_iv   = '0;
      r_sub  = '0;
      r_ordy = '1;
      r_took = '0;
      for (int g = 0; g < NCFG; g++) begin
         r_a[g] = '0;
         r_b[g] = '0;
      end
      dif.in_valid  = 1'b0;
      dif.op_a      = '0;
      dif.op_b      = '0;
      dif.op_sub    = 1'b0;
      dif.out_ready = 1'b1;
      test_reset();
      test_carry_chain();
      test_flags();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
